// File: rtl/syscall_console_tx_if.sv
// Request and character-stream signals between the syscall path and the console sink.
interface syscall_console_tx_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] sys_code;
  logic [31:0] arg0;
  logic [31:0] arg1;
  logic [31:0] arg2;
  logic [31:0] arg3;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;

  modport master (
    output req_valid, sys_code, arg0, arg1, arg2, arg3, char_ready,
    input  req_ready, char_valid, char_data
  );

  modport slave (
    input  req_valid, sys_code, arg0, arg1, arg2, arg3, char_ready,
    output req_ready, char_valid, char_data
  );
endinterface

// File: rtl/syscall_console_tx.sv
// Turns print/exit syscall requests into an ASCII character stream; holds the sticky halt state.
module syscall_console_tx #(
  parameter logic [31:0] CODE_PRINT_INT  = 32'd1,
  parameter logic [31:0] CODE_EXIT       = 32'd2,
  parameter logic [31:0] CODE_NOP        = 32'd3,
  parameter logic [31:0] CODE_STR_BASE   = 32'd4,
  parameter logic [31:0] CODE_PRINT_UINT = 32'd8
) (
  input  logic                       clk,
  input  logic                       reset,
  syscall_console_tx_if.slave        bus,
  output logic                       busy,
  output logic                       halted,
  output logic [15:0]                chars_sent
);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    EMIT_SIGN,
    EMIT_DIG,
    EMIT_STR,
    HALT
  } state_t;

  state_t      state, state_nx;

  logic [31:0] words [4];
  logic [1:0]  word_last;
  logic [1:0]  word_idx;
  logic [1:0]  byte_idx;
  logic        neg;

  logic [31:0] quo;
  logic [3:0]  rem;
  logic [4:0]  bit_cnt;
  logic [3:0]  digits [10];
  logic [3:0]  dig_cnt;
  logic [3:0]  emit_idx;

  logic        req_ready_c;
  logic        char_valid_c;
  logic [7:0]  char_data_c;
  logic        accept;
  logic        xfer;
  logic        is_str;
  logic        is_int;
  logic [31:0] mag;
  logic [7:0]  cur_byte;
  logic        str_step;

  logic [4:0]  rem_shift;
  logic        rem_ge;
  logic [3:0]  rem_nx;
  logic [31:0] quo_nx;
  logic        conv_last;
  logic        conv_done;

  assign bus.req_ready  = req_ready_c;
  assign bus.char_valid = char_valid_c;
  assign bus.char_data  = char_data_c;

  assign accept = bus.req_valid && req_ready_c;
  assign xfer   = char_valid_c && bus.char_ready;
  assign busy   = (state != IDLE) && (state != HALT);
  assign halted = (state == HALT);

  assign is_str = (bus.sys_code >= CODE_STR_BASE) && (bus.sys_code <= CODE_STR_BASE + 32'd3);
  assign is_int = (bus.sys_code == CODE_PRINT_INT) || (bus.sys_code == CODE_PRINT_UINT);
  assign mag    = ((bus.sys_code == CODE_PRINT_INT) && bus.arg0[31]) ? (~bus.arg0 + 32'd1) : bus.arg0;

  always_comb begin
    cur_byte = '0;
    case (byte_idx)
      2'd0: cur_byte = words[word_idx][31:24];
      2'd1: cur_byte = words[word_idx][23:16];
      2'd2: cur_byte = words[word_idx][15:8];
      default: cur_byte = words[word_idx][7:0];
    endcase
  end

  // NUL bytes advance on their own; real bytes advance only on a completed transfer.
  assign str_step = (cur_byte == 8'h00) || bus.char_ready;

  // One restoring-division step: the dividend shifts out of quo's MSB while quotient bits enter at the LSB.
  always_comb begin
    rem_shift = {rem, quo[31]};
    rem_ge    = (rem_shift >= 5'd10);
    rem_nx    = rem_ge ? 4'(rem_shift - 5'd10) : rem_shift[3:0];
    quo_nx    = {quo[30:0], rem_ge};
    conv_last = (bit_cnt == 5'd31);
    conv_done = conv_last && (quo_nx == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    req_ready_c  = 1'b0;
    char_valid_c = 1'b0;
    char_data_c  = '0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          if (bus.sys_code == CODE_EXIT)     state_nx = HALT;
          else if (bus.sys_code == CODE_NOP) state_nx = IDLE;
          else if (is_str)                   state_nx = EMIT_STR;
          else if (is_int)                   state_nx = CONV;
        end
      end
      CONV: begin
        if (conv_done) state_nx = neg ? EMIT_SIGN : EMIT_DIG;
      end
      EMIT_SIGN: begin
        char_valid_c = 1'b1;
        char_data_c  = 8'h2d;
        if (bus.char_ready) state_nx = EMIT_DIG;
      end
      EMIT_DIG: begin
        char_valid_c = 1'b1;
        char_data_c  = 8'h30 + {4'h0, digits[emit_idx]};
        if (bus.char_ready && (emit_idx == 4'd0)) state_nx = IDLE;
      end
      EMIT_STR: begin
        char_valid_c = (cur_byte != 8'h00);
        char_data_c  = cur_byte;
        if (str_step && (byte_idx == 2'd3) && (word_idx == word_last)) state_nx = IDLE;
      end
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chars_sent <= '0;
      word_last  <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      neg        <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      bit_cnt    <= '0;
      dig_cnt    <= '0;
      emit_idx   <= '0;
      for (int unsigned i = 0; i < 4; i++)  words[i]  <= '0;
      for (int unsigned i = 0; i < 10; i++) digits[i] <= '0;
    end else begin
      if (xfer) chars_sent <= chars_sent + 16'd1;
      case (state)
        IDLE: begin
          if (accept) begin
            words[0]  <= bus.arg0;
            words[1]  <= bus.arg1;
            words[2]  <= bus.arg2;
            words[3]  <= bus.arg3;
            word_last <= 2'(bus.sys_code - CODE_STR_BASE);
            word_idx  <= '0;
            byte_idx  <= '0;
            neg       <= (bus.sys_code == CODE_PRINT_INT) && bus.arg0[31];
            quo       <= mag;
            rem       <= '0;
            bit_cnt   <= '0;
            dig_cnt   <= '0;
          end
        end
        CONV: begin
          quo     <= quo_nx;
          rem     <= rem_nx;
          bit_cnt <= bit_cnt + 5'd1;
          if (conv_last) begin
            digits[dig_cnt] <= rem_nx;
            dig_cnt         <= dig_cnt + 4'd1;
            rem             <= '0;
            if (conv_done) emit_idx <= dig_cnt;
          end
        end
        EMIT_DIG: begin
          if (xfer && (emit_idx != 4'd0)) emit_idx <= emit_idx - 4'd1;
        end
        EMIT_STR: begin
          if (str_step) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) word_idx <= word_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_console_tx.sv
// Scoreboard bench for syscall_console_tx: expected characters come from a string-level model.
module tb_syscall_console_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic        halted;
  logic [15:0] chars_sent;

  syscall_console_tx_if bus_if ();

  syscall_console_tx dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .busy       (busy),
    .halted     (halted),
    .chars_sent (chars_sent)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;
  byte unsigned exp_q [$];
  logic [15:0]  exp_sent = '0;
  int unsigned  ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: expected text built from the service rules at string level.
  task automatic model_push(input logic [31:0] code, input logic [31:0] a [4]);
    string s;
    s = "";
    if (code == 32'd1) s = $sformatf("%0d", $signed(a[0]));
    else if (code == 32'd8) s = $sformatf("%0d", a[0]);
    else if (code >= 32'd4 && code <= 32'd7) begin
      for (int w = 0; w <= int'(code) - 4; w++)
        for (int b = 3; b >= 0; b--)
          if (a[w][b*8 +: 8] != 8'h00) s = {s, string'(a[w][b*8 +: 8])};
    end
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_sent = exp_sent + 16'(s.len());
  endtask

  // Monitor: compares every transfer against the scoreboard and checks stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, bus_if.char_valid}, 32'd1);
        check("stall_data", {24'd0, bus_if.char_data}, {24'd0, prev_data});
      end
      if (bus_if.char_valid && bus_if.char_ready) begin
        if (exp_q.size() == 0) check("unexpected_char", {24'd0, bus_if.char_data}, 32'hffff_ffff);
        else check("char", {24'd0, bus_if.char_data}, {24'd0, exp_q.pop_front()});
      end
      prev_stall = bus_if.char_valid && !bus_if.char_ready;
      prev_data  = bus_if.char_data;
    end
  end

  initial begin
    bus_if.char_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus_if.char_ready = 1'b1;
        1: bus_if.char_ready = ~bus_if.char_ready;
        default: bus_if.char_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] code, input logic [31:0] a0, a1, a2, a3);
    logic [31:0] a [4];
    int unsigned n = 0;
    while (!bus_if.req_ready && n < 2000) begin @(posedge clk); #1; n++; end
    if (!bus_if.req_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    model_push(code, a);
    bus_if.req_valid = 1'b1;
    bus_if.sys_code  = code;
    bus_if.arg0 = a0; bus_if.arg1 = a1; bus_if.arg2 = a2; bus_if.arg3 = a3;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    bus_if.sys_code  = $urandom;
    bus_if.arg0 = $urandom; bus_if.arg1 = $urandom; bus_if.arg2 = $urandom; bus_if.arg3 = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while (!bus_if.req_ready && n < 2000) begin @(posedge clk); #1; n++; end
    check({name, "_idle"}, {31'd0, bus_if.req_ready}, 32'd1);
    check({name, "_pending"}, exp_q.size(), 32'd0);
    check({name, "_chars_sent"}, {16'd0, chars_sent}, {16'd0, exp_sent});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_sent = '0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int b = 0; b < 4; b++)
      w[b*8 +: 8] = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom_range(33, 126));
    return w;
  endfunction

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.sys_code  = '0;
    bus_if.arg0 = '0; bus_if.arg1 = '0; bus_if.arg2 = '0; bus_if.arg3 = '0;
    do_reset();

    check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    check("rst_char_valid", {31'd0, bus_if.char_valid}, 32'd0);
    check("rst_char_data", {24'd0, bus_if.char_data}, 32'd0);
    check("rst_chars_sent", {16'd0, chars_sent}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // One word, sink always ready: four consecutive characters starting the cycle after accept.
    send(32'd4, "ABCD", 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("str1_valid_cycle", {31'd0, bus_if.char_valid}, 32'd1);
      @(posedge clk); #1;
    end
    check("str1_back_idle", {31'd0, bus_if.req_ready}, 32'd1);
    wait_idle("str1");

    ready_mode = 1;
    send(32'd7, "ABCD", "EFGH", "IJKL", "MNOP");
    wait_idle("str4_toggle");
    ready_mode = 0;

    send(32'd1, -32'sd1001, 32'd0, 32'd0, 32'd0);
    wait_idle("int_neg");
    send(32'd8, -32'sd1001, 32'd0, 32'd0, 32'd0);
    wait_idle("uint_big");
    send(32'd1, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_idle("int_zero");
    send(32'd1, 32'h8000_0000, 32'd0, 32'd0, 32'd0);
    wait_idle("int_min");
    send(32'd5, 32'h4100_4200, "EFGH", 32'd0, 32'd0);
    wait_idle("str_nul");

    send(32'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    send(32'd99, 32'd1, 32'd2, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    check("nop_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    wait_idle("nop");

    send(32'd2, 32'd0, 32'd0, 32'd0, 32'd0);
    check("exit_halted", {31'd0, halted}, 32'd1);
    check("exit_req_ready", {31'd0, bus_if.req_ready}, 32'd0);
    check("exit_busy", {31'd0, busy}, 32'd0);
    bus_if.req_valid = 1'b1;
    bus_if.sys_code  = 32'd4;
    bus_if.arg0      = "WXYZ";
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    check("halt_sticky", {31'd0, halted}, 32'd1);
    check("halt_no_char", {31'd0, bus_if.char_valid}, 32'd0);
    do_reset();
    check("halt_cleared", {31'd0, halted}, 32'd0);
    check("halt_rst_ready", {31'd0, bus_if.req_ready}, 32'd1);

    // Reset in the middle of "-1001" after two characters have gone out.
    send(32'd1, -32'sd1001, 32'd0, 32'd0, 32'd0);
    begin
      int unsigned n = 0;
      while (chars_sent != 16'd2 && n < 2000) begin @(posedge clk); #1; n++; end
      check("mid_reached_two", {16'd0, chars_sent}, 32'd2);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_sent = '0;
    check("mid_char_valid", {31'd0, bus_if.char_valid}, 32'd0);
    check("mid_chars_sent", {16'd0, chars_sent}, 32'd0);
    check("mid_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    send(32'd4, "WXYZ", 32'd0, 32'd0, 32'd0);
    wait_idle("post_reset_str");

    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] code;
      logic [31:0] v;
      case ($urandom_range(0, 5))
        0: code = 32'd1;
        1: code = 32'd8;
        2: code = 32'd3;
        default: code = 32'($urandom_range(4, 7));
      endcase
      v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 999)) : $urandom;
      if (code == 32'd1 || code == 32'd8)
        send(code, v, $urandom, $urandom, $urandom);
      else
        send(code, rand_word(), rand_word(), rand_word(), rand_word());
      if ($urandom_range(0, 1) == 0) wait_idle("rand");
    end
    wait_idle("rand_final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
